// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze, redirect, load-use interlock and fetch-wait handling.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_ctrl #(
   parameter int unsigned LOAD_USE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic [4:0]  ex_rd,
   input  logic        ex_is_load,
   input  logic        ex_branch_taken,
   input  logic        imem_ready,
   input  logic        dmem_busy,
   output logic        pc_wren,
   output logic        pc_sel,
   output logic        fd_wren,
   output logic        fd_flush,
   output logic        de_bubble,
   output logic        ex_hold,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   typedef enum logic [1:0] {RUN, ILOCK, REDIR_WAIT} state_t;

   localparam logic [2:0] ILOCK_RELOAD = 3'(LOAD_USE_CYCLES - 1);

   state_t     state, state_nxt;
   logic [2:0] ilock_cnt, ilock_cnt_nxt;
   logic       load_use;

   // r0 is hardwired zero, so a load targeting it never creates a dependency
   assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_rd)) ||
                      (id_uses_rt && (id_rt == ex_rd)));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= RUN;
         ilock_cnt <= 3'd0;
      end else begin
         state     <= state_nxt;
         ilock_cnt <= ilock_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      ilock_cnt_nxt = ilock_cnt;
      if (!dmem_busy) begin
         if (ex_branch_taken) begin
            ilock_cnt_nxt = 3'd0;
            state_nxt     = imem_ready ? RUN : REDIR_WAIT;
         end else begin
            case (state)
               REDIR_WAIT: if (imem_ready) state_nxt = RUN;
               ILOCK: begin
                  ilock_cnt_nxt = ilock_cnt - 3'd1;
                  if (ilock_cnt == 3'd1) state_nxt = RUN;
               end
               default: begin
                  if (load_use && (LOAD_USE_CYCLES > 1)) begin
                     state_nxt     = ILOCK;
                     ilock_cnt_nxt = ILOCK_RELOAD;
                  end
               end
            endcase
         end
      end
   end

   always_comb begin
      pc_wren   = 1'b0;
      pc_sel    = 1'b0;
      fd_wren   = 1'b0;
      fd_flush  = 1'b0;
      de_bubble = 1'b0;
      ex_hold   = 1'b0;
      if (!reset_n) begin
         pc_wren = 1'b0;
      end else if (dmem_busy) begin
         ex_hold = 1'b1;
      end else if (ex_branch_taken) begin
         pc_wren   = 1'b1;
         pc_sel    = 1'b1;
         fd_wren   = 1'b1;
         fd_flush  = 1'b1;
         de_bubble = 1'b1;
      end else if (state == REDIR_WAIT) begin
         // wrong-path word is discarded whether or not it has arrived
         fd_wren  = 1'b1;
         fd_flush = 1'b1;
      end else if ((state == ILOCK) || load_use) begin
         de_bubble = 1'b1;
      end else if (!imem_ready) begin
         fd_wren  = 1'b1;
         fd_flush = 1'b1;
      end else begin
         pc_wren = 1'b1;
         fd_wren = 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_cycles <= 32'd0;
         flush_count  <= 32'd0;
      end else begin
         if (!pc_wren && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
         if (fd_flush && (flush_count != 32'hFFFF_FFFF))  flush_count  <= flush_count + 32'd1;
      end
   end
`else
   assign stall_cycles = 32'd0;
   assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instance a (LOAD_USE_CYCLES=2) and b (LOAD_USE_CYCLES=3) share inputs.
module tb_hazard_ctrl;

   // control vector order: {pc_wren, pc_sel, fd_wren, fd_flush, de_bubble, ex_hold}
   localparam logic [5:0] ZERO  = 6'b000000;
   localparam logic [5:0] NORM  = 6'b101000;
   localparam logic [5:0] LU    = 6'b000010;
   localparam logic [5:0] REDIR = 6'b111110;
   localparam logic [5:0] FWAIT = 6'b001100;
   localparam logic [5:0] FRZ   = 6'b000001;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   logic [4:0] id_rs, id_rt, ex_rd;
   logic id_uses_rs, id_uses_rt, ex_is_load, ex_branch_taken, imem_ready, dmem_busy;

   logic a_pc_wren, a_pc_sel, a_fd_wren, a_fd_flush, a_de_bubble, a_ex_hold;
   logic b_pc_wren, b_pc_sel, b_fd_wren, b_fd_flush, b_de_bubble, b_ex_hold;
   logic [31:0] a_stall, a_flush, b_stall, b_flush;
   logic [5:0] ctl_a, ctl_b;

   int tests = 0;
   int fails = 0;

   assign ctl_a = {a_pc_wren, a_pc_sel, a_fd_wren, a_fd_flush, a_de_bubble, a_ex_hold};
   assign ctl_b = {b_pc_wren, b_pc_sel, b_fd_wren, b_fd_flush, b_de_bubble, b_ex_hold};

   always #5 clk = ~clk;

   hazard_ctrl #(.LOAD_USE_CYCLES(2)) dut_a (
      .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
      .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
      .imem_ready(imem_ready), .dmem_busy(dmem_busy),
      .pc_wren(a_pc_wren), .pc_sel(a_pc_sel), .fd_wren(a_fd_wren), .fd_flush(a_fd_flush),
      .de_bubble(a_de_bubble), .ex_hold(a_ex_hold),
      .stall_cycles(a_stall), .flush_count(a_flush));

   hazard_ctrl #(.LOAD_USE_CYCLES(3)) dut_b (
      .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
      .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
      .imem_ready(imem_ready), .dmem_busy(dmem_busy),
      .pc_wren(b_pc_wren), .pc_sel(b_pc_sel), .fd_wren(b_fd_wren), .fd_flush(b_fd_flush),
      .de_bubble(b_de_bubble), .ex_hold(b_ex_hold),
      .stall_cycles(b_stall), .flush_count(b_flush));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      ex_rd = 5'd0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
      imem_ready = 1'b1; dmem_busy = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      ex_branch_taken = 1'b1;
      @(negedge clk);
      tests++;
      if (ctl_a !== ZERO) begin fails++; $display("FAIL reset_ctl_a: got %b want %b", ctl_a, ZERO); end
      tests++;
      if (ctl_b !== ZERO) begin fails++; $display("FAIL reset_ctl_b: got %b want %b", ctl_b, ZERO); end
      tick();
      @(negedge clk);
      tests++;
      if (a_stall !== 32'd0 || a_flush !== 32'd0) begin
         fails++; $display("FAIL reset_counters: got stall %0d flush %0d want 0 0", a_stall, a_flush);
      end
      tick();
   endtask

   task automatic test_normal();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if (ctl_a !== NORM) begin fails++; $display("FAIL normal_c%0d: got %b want %b", i, ctl_a, NORM); end
         tick();
      end
      @(negedge clk);
      tests++;
      if (a_stall !== 32'd0) begin fails++; $display("FAIL normal_stall: got %0d want 0", a_stall); end
   endtask

   task automatic test_load_use();
      logic [5:0] exp_a [4];
      logic [5:0] exp_b [4];
      exp_a = '{LU, LU, NORM, NORM};
      exp_b = '{LU, LU, LU, NORM};
      do_reset();
      ex_is_load = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if (ctl_a !== exp_a[i]) begin fails++; $display("FAIL lu_rs_a_c%0d: got %b want %b", i, ctl_a, exp_a[i]); end
         tests++;
         if (ctl_b !== exp_b[i]) begin fails++; $display("FAIL lu_rs_b_c%0d: got %b want %b", i, ctl_b, exp_b[i]); end
         if (i == 2) begin
            tests++;
            if (a_stall !== (PERF ? 32'd2 : 32'd0)) begin
               fails++; $display("FAIL lu_stall_count: got %0d want %0d", a_stall, PERF ? 2 : 0);
            end
         end
         tick();
         ex_is_load = 1'b0;
      end
      // rt-side match, rs unused
      ex_is_load = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; id_uses_rs = 1'b0;
      @(negedge clk);
      tests++;
      if (ctl_a !== LU) begin fails++; $display("FAIL lu_rt: got %b want %b", ctl_a, LU); end
      tick();
      ex_is_load = 1'b0;
      tick();
      // r0 destination never stalls
      ex_is_load = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
      @(negedge clk);
      tests++;
      if (ctl_a !== NORM) begin fails++; $display("FAIL lu_r0: got %b want %b", ctl_a, NORM); end
      tick();
      // matching register but operand not read
      ex_rd = 5'd7; id_rs = 5'd7; id_rt = 5'd7; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      @(negedge clk);
      tests++;
      if (ctl_a !== NORM) begin fails++; $display("FAIL lu_unused: got %b want %b", ctl_a, NORM); end
      tick();
   endtask

   task automatic test_redirect();
      logic [5:0] exp [5];
      exp = '{REDIR, FWAIT, FWAIT, FWAIT, NORM};
      do_reset();
      ex_branch_taken = 1'b1; imem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (ctl_a !== exp[i]) begin fails++; $display("FAIL redir_c%0d: got %b want %b", i, ctl_a, exp[i]); end
         if (i == 4) begin
            tests++;
            if (a_flush !== (PERF ? 32'd4 : 32'd0) || a_stall !== (PERF ? 32'd3 : 32'd0)) begin
               fails++; $display("FAIL redir_counts: got flush %0d stall %0d want %0d %0d",
                                 a_flush, a_stall, PERF ? 4 : 0, PERF ? 3 : 0);
            end
         end
         tick();
         ex_branch_taken = 1'b0;
         imem_ready = (i >= 2);
      end
      // plain fetch wait from RUN
      imem_ready = 1'b0;
      @(negedge clk);
      tests++;
      if (ctl_a !== FWAIT) begin fails++; $display("FAIL fetch_wait: got %b want %b", ctl_a, FWAIT); end
      tick();
      imem_ready = 1'b1;
      ex_branch_taken = 1'b1;
      @(negedge clk);
      tests++;
      if (ctl_a !== REDIR) begin fails++; $display("FAIL redir_ready: got %b want %b", ctl_a, REDIR); end
      tick();
      ex_branch_taken = 1'b0;
      @(negedge clk);
      tests++;
      if (ctl_a !== NORM) begin fails++; $display("FAIL redir_ready_after: got %b want %b", ctl_a, NORM); end
      tick();
   endtask

   task automatic test_freeze();
      do_reset();
      ex_is_load = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1; dmem_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (ctl_a !== FRZ || ctl_b !== FRZ) begin
            fails++; $display("FAIL freeze_c%0d: got %b/%b want %b", i, ctl_a, ctl_b, FRZ);
         end
         tick();
      end
      dmem_busy = 1'b0;
      @(negedge clk);
      tests++;
      if (ctl_a !== LU) begin fails++; $display("FAIL freeze_lu0: got %b want %b", ctl_a, LU); end
      tick();
      ex_is_load = 1'b0;
      @(negedge clk);
      tests++;
      if (ctl_a !== LU) begin fails++; $display("FAIL freeze_lu1: got %b want %b", ctl_a, LU); end
      tick();
      @(negedge clk);
      tests++;
      if (ctl_a !== NORM) begin fails++; $display("FAIL freeze_done: got %b want %b", ctl_a, NORM); end
      tests++;
      if (a_stall !== (PERF ? 32'd7 : 32'd0)) begin
         fails++; $display("FAIL freeze_stall_count: got %0d want %0d", a_stall, PERF ? 7 : 0);
      end
      tick();
      // freeze outranks a taken branch and holds state
      dmem_busy = 1'b1; ex_branch_taken = 1'b1; imem_ready = 1'b0;
      @(negedge clk);
      tests++;
      if (ctl_a !== FRZ) begin fails++; $display("FAIL freeze_over_branch: got %b want %b", ctl_a, FRZ); end
      tick();
      dmem_busy = 1'b0; ex_branch_taken = 1'b0; imem_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (ctl_a !== NORM || a_flush !== 32'd0) begin
         fails++; $display("FAIL freeze_after_branch: got %b flush %0d want %b flush 0", ctl_a, a_flush, NORM);
      end
      tick();
   endtask

   task automatic test_branch_in_ilock();
      logic [5:0] exp [5];
      exp = '{LU, LU, REDIR, NORM, NORM};
      do_reset();
      ex_is_load = 1'b1; ex_rd = 5'd12; id_rt = 5'd12; id_uses_rt = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (ctl_b !== exp[i]) begin fails++; $display("FAIL ilock_branch_c%0d: got %b want %b", i, ctl_b, exp[i]); end
         tick();
         ex_is_load = 1'b0;
         ex_branch_taken = (i == 1);
      end
   endtask

   task automatic test_reset_redir();
      do_reset();
      ex_branch_taken = 1'b1; imem_ready = 1'b0;
      @(negedge clk);
      tests++;
      if (ctl_a !== REDIR) begin fails++; $display("FAIL rst_redir_c0: got %b want %b", ctl_a, REDIR); end
      tick();
      ex_branch_taken = 1'b0;
      @(negedge clk);
      tests++;
      if (ctl_a !== FWAIT) begin fails++; $display("FAIL rst_redir_wait: got %b want %b", ctl_a, FWAIT); end
      tick();
      reset_n = 1'b0;
      @(negedge clk);
      tests++;
      if (ctl_a !== ZERO || ctl_b !== ZERO) begin
         fails++; $display("FAIL rst_redir_during: got %b/%b want %b", ctl_a, ctl_b, ZERO);
      end
      tick();
      reset_n = 1'b1; imem_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (ctl_a !== NORM || ctl_b !== NORM) begin
         fails++; $display("FAIL rst_redir_after: got %b/%b want %b", ctl_a, ctl_b, NORM);
      end
      tests++;
      if (a_stall !== 32'd0 || a_flush !== 32'd0) begin
         fails++; $display("FAIL rst_redir_counters: got stall %0d flush %0d want 0 0", a_stall, a_flush);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_normal();
      test_load_use();
      test_redirect();
      test_freeze();
      test_branch_in_ilock();
      test_reset_redir();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control block that drives the write enables of the PC and IF/ID stage register.
- Also drives the PC source select, the IF/ID flush and the ID/EX bubble.
- Resolves data-memory freezes, taken branches, load-use interlocks and instruction-fetch wait states from ID/EX status each cycle.
- Sits beside the fetch stage; all pipeline-advance decisions originate here.

Parameters:
- LOAD_USE_CYCLES, 1, number of bubble cycles inserted per load-use hazard; legal range 1..7.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset
- id_rs  input  5  source register 1 of the instruction in ID
- id_rt  input  5  source register 2 of the instruction in ID
- id_uses_rs  input  1  ID instruction reads rs
- id_uses_rt  input  1  ID instruction reads rt
- ex_rd  input  5  destination register of the instruction in EX
- ex_is_load  input  1  EX instruction is a load
- ex_branch_taken  input  1  EX resolved a taken branch or jump
- imem_ready  input  1  fetch data for the current PC is valid; held while PC is unchanged
- dmem_busy  input  1  data memory access not complete
- pc_wren  output  1  PC write enable
- pc_sel  output  1  0 = PC+4, 1 = branch target
- fd_wren  output  1  IF/ID register write enable
- fd_flush  output  1  IF/ID loads NOP (0) instead of fetch data; only meaningful with fd_wren=1
- de_bubble  output  1  ID/EX loads NOP
- ex_hold  output  1  hold EX/MEM/WB registers
- stall_cycles  output  32  performance counter (see Optional Feature)
- flush_count  output  32  performance counter (see Optional Feature)

Behaviour:
- Interface: reset reset_n, synchronous, active-low; clock clk.
- Reset: state=RUN, ilock_cnt=0, counters=0.
  - While reset_n=0, outputs are forced to pc_wren=0, fd_wren=0, fd_flush=0, de_bubble=0, ex_hold=0, pc_sel=0.
- States: RUN, ILOCK, REDIR_WAIT.
- Outputs are combinational from state and inputs. State and ilock_cnt update on the clk edge.
- Per-cycle priority, highest first:
  1. Freeze: dmem_busy=1.
     - Outputs: ex_hold=1; all other controls 0.
     - State and ilock_cnt hold.
  2. Redirect: ex_branch_taken=1.
     - Outputs: pc_wren=1, pc_sel=1, fd_wren=1, fd_flush=1, de_bubble=1.
     - ilock_cnt cleared.
     - Next state is REDIR_WAIT if imem_ready=0, else RUN.
     - Overrides ILOCK and REDIR_WAIT.
  3. REDIR_WAIT: the in-flight fetch is wrong-path.
     - imem_ready=0: pc_wren=0, fd_wren=1, fd_flush=1; stay.
     - imem_ready=1: same outputs (the returned word is discarded); next state RUN.
  4. ILOCK: pc_wren=0, fd_wren=0, de_bubble=1; ilock_cnt decrements; next state RUN when ilock_cnt==1.
  5. Load-use, only when state is RUN.
     - Hazard condition: ex_is_load && ex_rd!=0 && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)).
     - Outputs: pc_wren=0, fd_wren=0, de_bubble=1.
     - If LOAD_USE_CYCLES>1: next state ILOCK with ilock_cnt=LOAD_USE_CYCLES-1.
  6. Fetch wait: imem_ready=0.
     - Outputs: pc_wren=0, fd_wren=1, fd_flush=1 (NOP into ID).
  7. Normal: pc_wren=1, pc_sel=0, fd_wren=1; other controls 0.
- Register 0 never creates a hazard.
- A taken branch during a load-use stall cancels the stall; the stalled ID instruction is flushed.
- Reset asserted in any state returns to RUN the next edge and discards pending REDIR_WAIT and ILOCK.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments every cycle with pc_wren=0 and reset_n=1.
  - flush_count increments every cycle with fd_flush=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: both ports are constant 0 and no counter flops exist.

Test Plan:
- imem_ready=1, no hazards, 4 cycles -> pc_wren=1, fd_wren=1, pc_sel=0 every cycle; stall_cycles stays 0.
- ex_is_load=1, ex_rd=5, id_rs=5, id_uses_rs=1, LOAD_USE_CYCLES=2 -> 2 consecutive cycles of pc_wren=0, fd_wren=0, de_bubble=1, then normal; stall_cycles=2 (macro on). Repeat with ex_rd=0 -> no stall.
- ex_branch_taken=1 with imem_ready=0, imem_ready rises 3 cycles later -> cycle 0: pc_wren=1, pc_sel=1, fd_flush=1, de_bubble=1; next 3 cycles: fd_flush=1, pc_wren=0; then normal. flush_count=4.
- dmem_busy=1 for 5 cycles in the same cycle as a load-use hazard -> ex_hold=1 and all else 0 for 5 cycles, then the load-use stall is applied.
- Branch taken in the second cycle of ILOCK (LOAD_USE_CYCLES=3) -> redirect outputs that cycle; RUN next with ilock_cnt=0.
- reset_n=0 for 1 cycle while in REDIR_WAIT -> state RUN, all controls 0 during reset, counters 0, normal fetch after release.
